// File: rtl/mack_bus_pkg.sv
// mack_bus_pkg -- shared definitions for the 68000 bus-cycle acknowledge logic.
//
// Contents:
//   state_e       acknowledge FSM states (IDLE, WAIT, EXT, ACK, AVEC, BERR)
//   *_DEF         default wait/timeout constants for top-level overrides
package mack_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // no bus cycle in progress
    ST_WAIT = 3'd1,  // counting wait states (ROM/RAM) or waiting for timeout (unmapped)
    ST_EXT  = 3'd2,  // waiting for the DUART's own DTACK
    ST_ACK  = 3'd3,  // DTACK asserted
    ST_AVEC = 3'd4,  // VPA asserted for an autovectored interrupt acknowledge
    ST_BERR = 3'd5   // BERR asserted
  } state_e;

  localparam int unsigned ROM_WAIT_DEF = 2;
  localparam int unsigned RAM_WAIT_DEF = 0;
  localparam int unsigned TIMEOUT_DEF  = 64;
  localparam int unsigned CNT_W_DEF    = 8;

endpackage

// File: rtl/mack_sync2.sv
// mack_sync2 -- two-flop synchroniser for an asynchronous active-low input.
// Both flops reset to 1 (the negated level) so nothing spurious is seen
// coming out of reset.
//
// Ports:
//   clk_i  clock
//   rst_i  synchronous reset, active-high
//   d_i    asynchronous input
//   q_o    synchronised output, two clocks behind d_i
module mack_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/mack_dtack_gen.sv
// mack_dtack_gen -- 68000 bus-cycle acknowledge generator.
// Sits behind the address decoder: inserts per-device wait states before
// DTACK, passes the DUART's DTACK through a synchroniser, autovectors
// interrupt-acknowledge cycles via VPA and raises BERR on unmapped or hung
// cycles. All outputs are registered decodes of the next state.
//
// Ports (all active-low except CLK/RST):
//   CLK       clock, all state on rising edge
//   RST       synchronous reset, active-high
//   AS        CPU address strobe
//   IACK      interrupt-acknowledge decode
//   ROMEN     ROM chip enable
//   RAMEN     RAM chip enable
//   DUARTEN   DUART chip enable
//   DTACK_IN  DUART DTACK, asynchronous
//   DTACK     data transfer acknowledge to CPU
//   BERR      bus error to CPU
//   VPA       valid peripheral address to CPU (autovector)
module mack_dtack_gen
  import mack_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT = ROM_WAIT_DEF,
  parameter int unsigned RAM_WAIT = RAM_WAIT_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic AS,
  input  logic IACK,
  input  logic ROMEN,
  input  logic RAMEN,
  input  logic DUARTEN,
  input  logic DTACK_IN,
  output logic DTACK,
  output logic BERR,
  output logic VPA
);

  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
  // The counter is cleared on the start edge and counts once per edge after
  // it, so it holds TIMEOUT-2 on the edge that must move to BERR.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 2);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic             unm_q, unm_d;
  logic             dtack_q, berr_q, vpa_q;
  logic             dtack_s;

  mack_sync2 u_dtack_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (DTACK_IN),
    .q_o   (dtack_s)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    to_d    = to_q;
    unm_d   = unm_q;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        to_d   = '0;
        unm_d  = 1'b0;
        if (!AS) begin
          if (!IACK) begin
            state_d = ST_AVEC;
          end else if (!DUARTEN) begin
            state_d = ST_EXT;
          end else if (!ROMEN) begin
            // ROM beats RAM: both are enabled together in the boot window.
            wait_d  = ROM_W;
            state_d = (ROM_W == 4'd0) ? ST_ACK : ST_WAIT;
          end else if (!RAMEN) begin
            wait_d  = RAM_W;
            state_d = (RAM_W == 4'd0) ? ST_ACK : ST_WAIT;
          end else begin
            // Unmapped: wait with no acknowledge so the timeout raises BERR.
            unm_d   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        to_d = to_q + CNT_W'(1);
        if (!unm_q) wait_d = wait_q - 4'd1;
        // Acknowledge is tested first so it wins a tie with the timeout.
        if (!unm_q && wait_q == 4'd1) state_d = ST_ACK;
        else if (to_q == TO_LAST)     state_d = ST_BERR;
      end
      ST_EXT: begin
        to_d = to_q + CNT_W'(1);
        if (!dtack_s)               state_d = ST_ACK;
        else if (to_q == TO_LAST)   state_d = ST_BERR;
      end
      default: ;  // ACK/AVEC/BERR hold until AS negates
    endcase
    // AS negated ends (or aborts) the cycle from any state.
    if (AS) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      to_q    <= '0;
      unm_q   <= 1'b0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
      vpa_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      unm_q   <= unm_d;
      dtack_q <= (state_d != ST_ACK);
      berr_q  <= (state_d != ST_BERR);
      vpa_q   <= (state_d != ST_AVEC);
    end
  end

  assign DTACK = dtack_q;
  assign BERR  = berr_q;
  assign VPA   = vpa_q;

endmodule
